// File: rtl/cutting_pkg.sv
// Shared types and defaults for the cutting-head motion sequencers.
// Used by cutting_step_sequencer and reusable by the track sequencer.
package cutting_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } seq_state_t;

    localparam int unsigned CNT_W_DEFAULT    = 16;
    localparam int unsigned DIV_W_DEFAULT    = 24;
    localparam int unsigned DIV_HALF_DEFAULT = 125000;

endpackage

// File: rtl/step_clk_gen.sv
// Free-running divider producing the 50% duty step clock for the stepper driver,
// plus single-cycle strobes aligned with each rising and falling step_clk edge.
module step_clk_gen #(
    parameter int unsigned DIV_W    = 24,
    parameter int unsigned DIV_HALF = 125000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic step_clk_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV_HALF - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             step_clk_q, step_clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             wrap;

    always_comb begin
        wrap       = (div_cnt_q == DivLast);
        div_cnt_d  = wrap ? '0 : div_cnt_q + DIV_W'(1);
        step_clk_d = step_clk_q ^ wrap;
        // Strobes are registered alongside step_clk so they mark the cycle the edge appears.
        rise_d     = wrap & ~step_clk_q;
        fall_d     = wrap & step_clk_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            step_clk_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            step_clk_q <= step_clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign step_clk_o = step_clk_q;
    assign rise_stb_o = rise_q;
    assign fall_stb_o = fall_q;

endmodule

// File: rtl/cutting_step_sequencer.sv
// Move-command sequencer feeding the cutting stepper driver: accepts "N steps in
// direction D", gates driver enable around whole step_clk periods, then reports done.
module cutting_step_sequencer
    import cutting_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned DIV_W    = DIV_W_DEFAULT,
    parameter int unsigned DIV_HALF = DIV_HALF_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [CNT_W-1:0] cmd_steps_i,
    input  logic             cmd_dir_i,
    input  logic             abort_i,
    output logic             step_clk_o,
    output logic             motor_en_o,
    output logic             motor_dir_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [CNT_W-1:0] steps_left_o
);

    seq_state_t       state_q;
    logic             cmd_ready_q;
    logic             motor_en_q;
    logic             motor_dir_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic [CNT_W-1:0] steps_left_q;

    logic rise_stb;
    logic fall_stb;
    logic xfer;
    logic left_zero;

    step_clk_gen #(
        .DIV_W    (DIV_W),
        .DIV_HALF (DIV_HALF)
    ) u_step_clk_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .step_clk_o (step_clk_o),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    assign xfer      = cmd_valid_i & cmd_ready_q;
    assign left_zero = (steps_left_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            motor_en_q   <= 1'b0;
            motor_dir_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            steps_left_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_steps_i != '0) begin
                            steps_left_q <= cmd_steps_i;
                            motor_dir_q  <= cmd_dir_i;
                            busy_q       <= 1'b1;
                            state_q      <= ARM;
                        end else begin
                            aborted_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                ARM: begin
                    // Enable only after a falling edge so the driver never sees a partial high phase.
                    if (fall_stb) begin
                        motor_en_q <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (rise_stb && !left_zero) begin
                        steps_left_q <= steps_left_q - CNT_W'(1);
                    end
                    if (fall_stb && (left_zero || abort_i)) begin
                        motor_en_q <= 1'b0;
                        aborted_q  <= !left_zero;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign motor_en_o   = motor_en_q;
    assign motor_dir_o  = motor_dir_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign steps_left_o = steps_left_q;

endmodule
